// File: rtl/seq_detect_ctrl.sv
// Serial bit-pattern detector with a run controller: counts matches of a
// programmable 1..MAXLEN-bit pattern and stops after a target count.
module seq_detect_ctrl #(
  parameter  int MAXLEN = 8,
  localparam int LW     = $clog2(MAXLEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LW-1:0]     cfg_len,
  input  logic              cfg_overlap,
  input  logic [7:0]        cfg_target,
  input  logic              start,
  input  logic              abort,
  input  logic              din,
  input  logic              din_valid,
  output logic              match,
  output logic [7:0]        match_count,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [MAXLEN-1:0] pat_q, pat_d;
  logic [LW-1:0]     len_q, len_d;
  logic              ovl_q, ovl_d;
  logic [7:0]        tgt_q, tgt_d;
  logic [MAXLEN-1:0] hist_q, hist_d;
  logic [LW-1:0]     fill_q, fill_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              match_q, match_d;
  logic              err_q, err_d;

  logic              len_ok;
  logic              accept;
  logic              fill_ok;
  logic              hit;
  logic [MAXLEN-1:0] shifted;
  logic [MAXLEN-1:0] mask;
  logic [7:0]        cnt_inc;
  logic [LW-1:0]     fill_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= MAXLEN'(8'h0B);
      len_q   <= LW'(4);
      ovl_q   <= 1'b1;
      tgt_q   <= 8'd0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= 8'd0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      tgt_q   <= tgt_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      err_q   <= err_d;
    end
  end

  // A match needs enough fresh bits (fill) and the low len bits to agree.
  always_comb begin
    len_ok   = (len_q != '0) && (len_q <= LW'(MAXLEN));
    accept   = (state_q == S_RUN) && din_valid;
    shifted  = {hist_q[MAXLEN-2:0], din};
    mask     = ~({MAXLEN{1'b1}} << len_q);
    fill_ok  = ({1'b0, fill_q} + 1'b1) >= {1'b0, len_q};
    hit      = accept && fill_ok && ((shifted & mask) == (pat_q & mask));
    cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    fill_inc = (fill_q == LW'(MAXLEN)) ? fill_q : fill_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    tgt_d   = tgt_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    err_d   = 1'b0;

    // Priority: abort, then start, then bit acceptance.
    if (abort) begin
      state_d = S_IDLE;
      fill_d  = '0;
    end else if (start) begin
      if (len_ok) begin
        state_d = S_RUN;
        cnt_d   = 8'd0;
        hist_d  = '0;
        fill_d  = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (accept) begin
      hist_d = shifted;
      fill_d = fill_inc;
      if (hit) begin
        match_d = 1'b1;
        cnt_d   = cnt_inc;
        if (!ovl_q) fill_d = '0;
        if ((tgt_q != 8'd0) && (cnt_inc == tgt_q)) state_d = S_DONE;
      end
    end

    if (cfg_we && (state_q != S_RUN)) begin
      pat_d = cfg_pattern;
      len_d = cfg_len;
      ovl_d = cfg_overlap;
      tgt_d = cfg_target;
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: a bit-queue reference model
// pushes expected outputs per cycle, compared after each clock edge.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst, cfg_we, cfg_overlap, start, abort, din, din_valid;
  logic [7:0] cfg_pattern, cfg_target;
  logic [3:0] cfg_len;
  logic       match, busy, done, cfg_err;
  logic [7:0] match_count;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.MAXLEN(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .abort(abort), .din(din), .din_valid(din_valid),
    .match(match), .match_count(match_count), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  typedef struct {
    logic       match;
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pulses = 0;
  int   n_err_pulses = 0;

  // reference model state: 0 idle, 1 run, 2 done
  int         m_state;
  logic [7:0] m_pat, m_tgt, m_cnt;
  int         m_len;
  bit         m_ovl, m_match, m_err;
  bit         hq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit tail_eq();
    for (int k = 0; k < m_len; k++)
      if (hq[hq.size() - 1 - k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    int old_state = m_state;
    m_match = 1'b0;
    m_err   = 1'b0;
    if (rst) begin
      m_state = 0; m_cnt = 8'd0; hq.delete();
      m_pat = 8'h0B; m_len = 4; m_ovl = 1'b1; m_tgt = 8'd0;
      return;
    end
    if (abort) begin
      m_state = 0;
      hq.delete();
    end else if (start) begin
      if (m_len >= 1 && m_len <= 8) begin
        m_state = 1; m_cnt = 8'd0; hq.delete();
      end else begin
        m_err = 1'b1;
      end
    end else if (m_state == 1 && din_valid) begin
      hq.push_back(din);
      if (hq.size() > 8) void'(hq.pop_front());
      if (hq.size() >= m_len && tail_eq()) begin
        m_match = 1'b1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        if (!m_ovl) hq.delete();
        if (m_tgt != 0 && m_cnt == m_tgt) m_state = 2;
      end
    end
    if (cfg_we && old_state != 1) begin
      m_pat = cfg_pattern; m_len = cfg_len; m_ovl = cfg_overlap; m_tgt = cfg_target;
    end
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    e.match = m_match; e.cnt = m_cnt; e.busy = (m_state == 1);
    e.done = (m_state == 2); e.err = m_err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("match", match, e.match);
    check("match_count", match_count, e.cnt);
    check("busy", busy, e.busy);
    check("done", done, e.done);
    check("cfg_err", cfg_err, e.err);
    if (match === 1'b1) n_pulses++;
    if (cfg_err === 1'b1) n_err_pulses++;
    rst = 0; cfg_we = 0; start = 0; abort = 0; din = 0; din_valid = 0;
  endtask

  task automatic cyc(input bit s, input bit a, input bit d, input bit v);
    start = s; abort = a; din = d; din_valid = v;
    tick();
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input bit ovl, input logic [7:0] tgt);
    cfg_we = 1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_target = tgt;
    tick();
  endtask

  // seq[n-1] is sent first; gap idle cycles follow each bit
  task automatic feed(input logic [15:0] seq, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      cyc(0, 0, seq[i], 1);
      repeat (gap) cyc(0, 0, 0, 0);
    end
  endtask

  initial begin
    rst = 1; cfg_we = 0; start = 0; abort = 0; din = 0; din_valid = 0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 0; cfg_target = 8'd0;
    m_state = 0; m_cnt = 0; m_pat = 0; m_len = 0; m_ovl = 0; m_tgt = 0;
    tick();
    rst = 1; tick();
    check("rst_match_count", match_count, 0);

    // default shadow: 0B, len 4, overlap, free-run
    n_pulses = 0;
    cyc(1, 0, 0, 0);
    feed(16'b1011011, 7, 0);
    cyc(0, 0, 0, 0);
    check("ovl_pulses", n_pulses, 2);
    check("ovl_count", match_count, 2);

    // din_valid ignored while idle
    cyc(0, 1, 0, 0);
    feed(16'b1011, 4, 0);
    cfg(8'h0B, 4'd4, 1'b0, 8'd0);
    n_pulses = 0;
    cyc(1, 0, 0, 0);
    feed(16'b1011011, 7, 0);
    check("novl_pulses", n_pulses, 1);
    check("novl_count", match_count, 1);

    // target 3, then bits in DONE ignored; cfg write in RUN ignored
    cyc(0, 1, 0, 0);
    cfg(8'h03, 4'd2, 1'b1, 8'd3);
    n_pulses = 0;
    cyc(1, 0, 0, 0);
    cfg(8'h00, 4'd0, 1'b0, 8'd0);
    feed(16'b1111, 4, 0);
    check("tgt_done", done, 1);
    check("tgt_busy", busy, 0);
    feed(16'b1111, 4, 0);
    check("tgt_pulses", n_pulses, 3);
    check("tgt_count", match_count, 3);

    // gaps in the stream, started from DONE
    cfg(8'h0B, 4'd4, 1'b1, 8'd0);
    n_pulses = 0;
    cyc(1, 0, 0, 0);
    feed(16'b1011, 4, 3);
    check("gap_pulses", n_pulses, 1);

    // abort discards partial match
    n_pulses = 0;
    cyc(1, 0, 0, 0);
    feed(16'b101, 3, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    feed(16'b1, 1, 0);
    cyc(0, 0, 0, 0);
    check("abort_pulses", n_pulses, 0);
    check("abort_count", match_count, 0);

    // illegal lengths rejected
    cyc(0, 1, 0, 0);
    n_err_pulses = 0;
    cfg(8'h0B, 4'd0, 1'b1, 8'd0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cfg(8'h0B, 4'd9, 1'b1, 8'd0);
    cyc(1, 0, 0, 0);
    check("err_pulses", n_err_pulses, 2);
    check("err_busy", busy, 0);

    // len 8 boundary, then reset mid-run
    cfg(8'hA5, 4'd8, 1'b1, 8'd0);
    n_pulses = 0;
    cyc(1, 0, 0, 0);
    feed(16'b1010010110100101, 16, 0);
    check("len8_pulses", n_pulses, 2);
    feed(16'b101, 3, 0);
    rst = 1; tick();
    check("rst_run_busy", busy, 0);
    check("rst_run_count", match_count, 0);
    feed(16'b1011, 4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
